// File: rtl/div_if.sv
// Handshake and data bundle between the execute stage and the multi-cycle divider.
// The master side (EX) issues operands and start/annul; the slave side (divider) returns the result.
interface div_if #(
   parameter int WIDTH = 32
);
   logic               signed_div_i;
   logic [WIDTH-1:0]   opdata1_i;
   logic [WIDTH-1:0]   opdata2_i;
   logic               start_i;
   logic               annul_i;
   logic [2*WIDTH-1:0] result_o;
   logic               ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned radix-2 restoring divider, one quotient bit per clock.
// Result is {remainder, quotient}; flushable through annul_i.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic  clk,
   input  logic  rst,
   div_if.slave  bus
);

   localparam int               CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]    CNT_DONE = CW'(WIDTH);
   localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
   localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
   localparam logic [2*WIDTH-1:0] ZERO_RES = {(2*WIDTH){1'b0}};

   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_BYZERO = 2'd1,
      ST_ON     = 2'd2,
      ST_END    = 2'd3
   } state_t;

   // Magnitude of an operand; only negative values in signed mode are flipped.
   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
      abs_val = (sgn && v[WIDTH-1]) ? (ZERO_W - v) : v;
   endfunction

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
      cond_neg = neg ? (ZERO_W - v) : v;
   endfunction

   state_t             state_r,    state_s;
   logic [CW-1:0]      cnt_r,      cnt_s;
   logic [2*WIDTH:0]   work_r,     work_s;
   logic [WIDTH-1:0]   divisor_r,  divisor_s;
   logic               neg_quot_r, neg_quot_s;
   logic               neg_rem_r,  neg_rem_s;
   logic [2*WIDTH-1:0] result_r,   result_s;
   logic               ready_r,    ready_s;

   logic               fits_s;
   logic [WIDTH-1:0]   diff_s;

   // Trial subtraction of the divisor from the top WIDTH+1 bits of the working register.
   // When the divisor fits, the difference is below 2^WIDTH, so the low WIDTH bits suffice.
   assign fits_s = (work_r[2*WIDTH:WIDTH] >= {1'b0, divisor_r});
   assign diff_s = work_r[2*WIDTH-1:WIDTH] - divisor_r;

   // Next-state and next-output logic.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      work_s     = work_r;
      divisor_s  = divisor_r;
      neg_quot_s = neg_quot_r;
      neg_rem_s  = neg_rem_r;
      result_s   = result_r;
      ready_s    = ready_r;
      case (state_r)
         ST_FREE: begin
            result_s = ZERO_RES;
            ready_s  = 1'b0;
            if (bus.start_i && !bus.annul_i) begin
               if (bus.opdata2_i == ZERO_W) begin
                  state_s = ST_BYZERO;
               end else begin
                  state_s    = ST_ON;
                  cnt_s      = CNT_ZERO;
                  // Dividend sits one bit up so the first trial sees its MSB.
                  work_s     = {ZERO_W, abs_val(bus.opdata1_i, bus.signed_div_i), 1'b0};
                  divisor_s  = abs_val(bus.opdata2_i, bus.signed_div_i);
                  neg_quot_s = bus.signed_div_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                  neg_rem_s  = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
               end
            end else begin
               state_s = ST_FREE;
            end
         end
         ST_BYZERO: begin
            state_s  = ST_END;
            result_s = ZERO_RES;
            ready_s  = 1'b1;
         end
         ST_ON: begin
            if (bus.annul_i) begin
               state_s  = ST_FREE;
               result_s = ZERO_RES;
               ready_s  = 1'b0;
            end else if (cnt_r < CNT_DONE) begin
               cnt_s = cnt_r + CNT_ONE;
               if (fits_s) begin
                  work_s = {diff_s, work_r[WIDTH-1:0], 1'b1};
               end else begin
                  work_s = {work_r[2*WIDTH-1:0], 1'b0};
               end
            end else begin
               // Remainder ends up one bit above the quotient half.
               result_s = {cond_neg(work_r[2*WIDTH:WIDTH+1], neg_rem_r),
                           cond_neg(work_r[WIDTH-1:0], neg_quot_r)};
               ready_s  = 1'b1;
               state_s  = ST_END;
            end
         end
         ST_END: begin
            if (bus.start_i) begin
               ready_s = 1'b1;
            end else begin
               state_s  = ST_FREE;
               result_s = ZERO_RES;
               ready_s  = 1'b0;
            end
         end
         default: begin
            state_s  = ST_FREE;
            result_s = ZERO_RES;
            ready_s  = 1'b0;
         end
      endcase
   end

   // State, working and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_FREE;
         cnt_r      <= CNT_ZERO;
         work_r     <= {(2*WIDTH+1){1'b0}};
         divisor_r  <= ZERO_W;
         neg_quot_r <= 1'b0;
         neg_rem_r  <= 1'b0;
         result_r   <= ZERO_RES;
         ready_r    <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         work_r     <= work_s;
         divisor_r  <= divisor_s;
         neg_quot_r <= neg_quot_s;
         neg_rem_r  <= neg_rem_s;
         result_r   <= result_s;
         ready_r    <= ready_s;
      end
   end

   assign bus.result_o = result_r;
   assign bus.ready_o  = ready_r;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: 32-bit and 8-bit instances, directed and random operands,
// expected results from plain integer division pushed into queues and popped by monitors.
module tb_div_unit;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   logic [63:0] exp32_q[$];
   logic [15:0] exp8_q[$];
   logic        prev32;
   logic        prev8;

   div_if #(.WIDTH(32)) b32 ();
   div_if #(.WIDTH(8))  b8 ();

   div_unit #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32));
   div_unit #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Reference: truncating integer division; divide-by-zero returns zero.
   function automatic logic [63:0] ref32(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   function automatic logic [15:0] ref8(input bit sgn, input logic [7:0] a, input logic [7:0] b);
      int sa, sb, q, r;
      if (b == 8'd0) return 16'd0;
      if (sgn) begin
         sa = int'($signed(a));
         sb = int'($signed(b));
      end else begin
         sa = int'({24'd0, a});
         sb = int'({24'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[7:0], q[7:0]};
   endfunction

   // Monitors: compare each fresh ready pulse against the oldest expectation.
   always @(negedge clk) begin
      if (rst && b32.ready_o && !prev32) begin
         if (exp32_q.size() == 0) chk("unexpected_ready32", 64'd1, 64'd0);
         else chk("result32", b32.result_o, exp32_q.pop_front());
      end
      prev32 <= b32.ready_o;
   end

   always @(negedge clk) begin
      if (rst && b8.ready_o && !prev8) begin
         if (exp8_q.size() == 0) chk("unexpected_ready8", 64'd1, 64'd0);
         else chk("result8", {48'd0, b8.result_o}, {48'd0, exp8_q.pop_front()});
      end
      prev8 <= b8.ready_o;
   end

   task automatic run32(input bit sgn, input logic [31:0] a, input logic [31:0] b, input bit drop);
      int n;
      bit seen;
      logic [63:0] e;
      e = ref32(sgn, a, b);
      @(negedge clk);
      b32.signed_div_i = sgn;
      b32.opdata1_i    = a;
      b32.opdata2_i    = b;
      b32.annul_i      = 1'b0;
      b32.start_i      = 1'b1;
      exp32_q.push_back(e);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 100) begin
         @(posedge clk);
         n++;
         #1;
         if (n == 1) begin
            b32.opdata1_i    = $urandom;
            b32.opdata2_i    = $urandom;
            b32.signed_div_i = 1'($urandom_range(0, 1));
            if (b == 32'd0) b32.annul_i = 1'b1;
         end
         seen = b32.ready_o;
      end
      chk("latency32", 64'(n), (b == 32'd0) ? 64'd2 : 64'd34);
      b32.annul_i = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("hold_ready32", {63'd0, b32.ready_o}, 64'd1);
         chk("hold_result32", b32.result_o, e);
      end
      b32.annul_i = 1'b0;
      if (drop) begin
         @(negedge clk);
         b32.start_i = 1'b0;
         @(posedge clk);
         #1;
         chk("drop_ready32", {63'd0, b32.ready_o}, 64'd0);
         chk("drop_result32", b32.result_o, 64'd0);
      end
   endtask

   task automatic run8(input bit sgn, input logic [7:0] a, input logic [7:0] b);
      int n;
      bit seen;
      logic [15:0] e;
      e = ref8(sgn, a, b);
      @(negedge clk);
      b8.signed_div_i = sgn;
      b8.opdata1_i    = a;
      b8.opdata2_i    = b;
      b8.annul_i      = 1'b0;
      b8.start_i      = 1'b1;
      exp8_q.push_back(e);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 100) begin
         @(posedge clk);
         n++;
         #1;
         if (n == 1) begin
            b8.opdata1_i    = 8'($urandom);
            b8.opdata2_i    = 8'($urandom);
            b8.signed_div_i = 1'($urandom_range(0, 1));
         end
         seen = b8.ready_o;
      end
      chk("latency8", 64'(n), (b == 8'd0) ? 64'd2 : 64'd10);
      @(negedge clk);
      b8.start_i = 1'b0;
      @(posedge clk);
      #1;
      chk("drop_ready8", {63'd0, b8.ready_o}, 64'd0);
      chk("drop_result8", {48'd0, b8.result_o}, 64'd0);
   endtask

   initial begin
      total = 0;
      bad = 0;
      prev32 = 1'b0;
      prev8 = 1'b0;
      rst = 1'b0;
      b32.signed_div_i = 1'b0; b32.opdata1_i = 32'd0; b32.opdata2_i = 32'd0;
      b32.start_i = 1'b0;      b32.annul_i = 1'b0;
      b8.signed_div_i = 1'b0;  b8.opdata1_i = 8'd0;   b8.opdata2_i = 8'd0;
      b8.start_i = 1'b0;       b8.annul_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready32", {63'd0, b32.ready_o}, 64'd0);
      chk("reset_result32", b32.result_o, 64'd0);
      chk("reset_result8", {48'd0, b8.result_o}, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Directed cases.
      run32(1'b0, 32'd100, 32'd7, 1'b1);
      chk("ref_100_7", ref32(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
      run32(1'b1, 32'hFFFFFFF9, 32'h2, 1'b1);
      run32(1'b1, 32'd7, 32'hFFFFFFFE, 1'b1);
      run32(1'b0, 32'hFFFFFFF9, 32'h2, 1'b1);
      run32(1'b1, 32'h12345678, 32'd0, 1'b1);
      run32(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1);
      run32(1'b0, 32'd5, 32'd9, 1'b1);

      // annul in FREE blocks a divide-by-zero start.
      @(negedge clk);
      b32.opdata1_i = 32'd5; b32.opdata2_i = 32'd0;
      b32.annul_i = 1'b1;    b32.start_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("annul_free_ready32", {63'd0, b32.ready_o}, 64'd0);
      @(negedge clk);
      b32.start_i = 1'b0;
      b32.annul_i = 1'b0;

      // annul at edge 10 of 1000/3, then 20/6 straight after.
      @(negedge clk);
      b32.signed_div_i = 1'b0; b32.opdata1_i = 32'd1000; b32.opdata2_i = 32'd3;
      b32.start_i = 1'b1;
      repeat (9) @(posedge clk);
      @(negedge clk);
      b32.annul_i = 1'b1;
      @(posedge clk);
      #1;
      chk("annul_on_ready32", {63'd0, b32.ready_o}, 64'd0);
      run32(1'b0, 32'd20, 32'd6, 1'b1);

      // Asynchronous reset mid-operation.
      @(negedge clk);
      b32.opdata1_i = 32'd50; b32.opdata2_i = 32'd5; b32.start_i = 1'b1;
      repeat (15) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_mid_ready32", {63'd0, b32.ready_o}, 64'd0);
      chk("rst_mid_result32", b32.result_o, 64'd0);
      b32.start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // Asynchronous reset while a result is held.
      run32(1'b0, 32'd77, 32'd7, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk("rst_end_ready32", {63'd0, b32.ready_o}, 64'd0);
      chk("rst_end_result32", b32.result_o, 64'd0);
      b32.start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      run32(1'b0, 32'd9, 32'd4, 1'b1);

      // 8-bit instance.
      run8(1'b0, 8'd200, 8'd9);
      run8(1'b1, 8'h80, 8'hFF);
      run8(1'b1, 8'h85, 8'd0);

      // Randomized operands; small divisors and zero appear by mixing ranges.
      for (int i = 0; i < 16; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: b = 32'hFFFFFFFF - 32'($urandom_range(0, 7));
            default: b = $urandom;
         endcase
         run32(1'($urandom_range(0, 1)), a, b, 1'b1);
      end
      for (int i = 0; i < 16; i++) begin
         run8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 255)));
      end

      repeat (2) @(posedge clk);
      #1;
      chk("drained32", 64'(exp32_q.size()), 64'd0);
      chk("drained8", 64'(exp8_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Parametrised multi-cycle integer divider for the execute stage.
- Performs signed or unsigned radix-2 restoring division, one quotient bit per clock.
- EX starts it with a start/ready handshake and stalls the pipeline until ready_o.
- Result format is {remainder, quotient}; EX maps remainder to HI and quotient to LO.
- Supports cancellation by a pipeline flush (annul_i).

Parameters:
- WIDTH, 32, operand width in bits; must be ≥ 4. The counter is $clog2(WIDTH)+1 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- signed_div_i  in  1  1 = two's-complement division, 0 = unsigned.
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- start_i  in  1  request; level-sensitive, held by EX until ready_o is seen.
- annul_i  in  1  cancel the in-flight operation (flush).
- result_o  out  2*WIDTH  {remainder[2*WIDTH-1:WIDTH], quotient[WIDTH-1:0]}; registered.
- ready_o  out  1  result valid; registered.

Behaviour:
- Reset (rst=0, asynchronous): state=FREE, cnt=0, ready_o=0, result_o=0, working registers=0. Reset mid-operation aborts with no residue.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1 and annul_i=0 and opdata2_i=0 -> BYZERO.
  - start_i=1 and annul_i=0 and opdata2_i≠0 -> ON, cnt=0. Latch |dividend|, |divisor|, the quotient sign (signed_div_i & sign1^sign2) and the remainder sign (signed_div_i & sign1).
  - Absolute values are taken only when signed_div_i=1 and the operand MSB is 1.
  - Otherwise stay in FREE; ready_o=0, result_o=0.
- BYZERO: next edge -> END, result_o=0, ready_o=1.
- ON, per edge with cnt<WIDTH:
  - Working register dividend is 2*WIDTH+1 bits.
  - Trial subtraction: upper WIDTH+1 bits minus {0,|divisor|}.
  - On a negative trial, shift left and insert 0; otherwise replace the upper bits with the difference, shift, and insert 1.
  - cnt++.
- ON, edge with cnt==WIDTH:
  - Quotient/remainder = low/high halves.
  - Negate the quotient if its sign flag is set; negate the remainder if its sign flag is set.
  - Register the result into result_o, set ready_o=1, go to END.
- ON with annul_i=1 (takes priority over iteration) -> FREE; ready_o=0, result_o=0.
- END: hold result_o and ready_o=1 while start_i=1. start_i=0 -> FREE with ready_o=0 and result_o=0 on that edge.
- Latency: counting the edge that samples start_i in FREE as edge 1, ready_o is high after edge WIDTH+2 (34 for WIDTH=32). Divide-by-zero gives ready_o after edge 2.
- Operand inputs are ignored after edge 1; changes mid-operation have no effect.
- Signed overflow MIN/-1: quotient=MIN (wraps), remainder=0. Never flagged.
- annul_i in BYZERO or END has no effect. In FREE it blocks the start.
- Arithmetic is modulo 2^WIDTH. No X may propagate to outputs for any input values.

Test Plan:
- WIDTH=32 unsigned 100/7, start held -> ready_o rises after edge 34, result_o={32'd2, 32'd14}. Drop start -> ready_o=0 and result_o=0 after the next edge.
- Signed -7/2 (0xFFFFFFF9/0x2) -> result_o={0xFFFFFFFF, 0xFFFFFFFD}.
- Signed 7/-2 -> {0x00000001, 0xFFFFFFFD}.
- Unsigned 0xFFFFFFF9/2 -> {1, 0x7FFFFFFC}.
- Divisor 0 -> ready_o after edge 2, result_o=0. Signed 0x80000000/0xFFFFFFFF -> {0, 0x80000000}.
- annul_i pulsed at edge 10 of a 1000/3 operation -> FREE, ready_o stays 0. A new start 20/6 immediately after -> {2, 3} after 34 edges.
- rst pulled low asynchronously at edge 15 mid-operation -> outputs 0 immediately. After release, 9/4 -> {1, 2}.
- WIDTH=8 instance: unsigned 200/9 -> {8'd2, 8'd22} after edge 10. Signed -128/-1 -> {0, 0x80}.
